cic_rate_ctrl: RTL and testbench
================================

Name: cic_rate_ctrl

Overview:
Run-time decimation-rate controller that sits between the configuration bus and the CIC filter instance.
- Accepts a requested decimation factor and waits for an output-sample boundary.
- Holds the filter in reset to flush integrator/comb state, applies the new factor, then suppresses the transient outputs until the comb chain has settled.
- Gates both the input strobe into the filter and the output valid from the filter, so downstream logic only ever sees clean samples.

Parameters:
N, 2, CIC order of the controlled filter; used for the settle count
M, 1, comb delay of the controlled filter; used for the settle count
OutDataWidth, 28, filter output data width
DefaultDecim, 3'd0, decimation code applied after reset
FlushCycles, 4, cycles CicRst_o is held high per flush (range 1..15)
BoundTimeout, 255, max cycles to wait for an output boundary (8-bit counter)

Ports:
Clk_i  in  1  single clock
Rst_i  in  1  synchronous active-high reset
CfgDecim_i  in  3  requested decimation code
CfgWr_i  in  1  one-cycle strobe; CfgDecim_i valid
CfgAck_o  out  1  one-cycle pulse: request completed
CfgErr_o  out  1  one-cycle pulse: request rejected
Busy_o  out  1  high while not in RUN
DataNd_i  in  1  ADC sample strobe
DataNd_o  out  1  gated strobe to filter DataNd_i
DecimFactor_o  out  3  to filter DecimFactor_i
CicRst_o  out  1  to filter Rst_i (ORed with Rst_i in this block)
CicData_i  in  OutDataWidth  filter Data_o
CicDataValid_i  in  1  filter DataValid_o
Data_o  out  OutDataWidth  = CicData_i, combinational passthrough
DataValid_o  out  1  gated CicDataValid_i

Behaviour:
Reset (Rst_i=1 sampled on a rising edge):
- State = FLUSH; DecimFactor_o = DefaultDecim; CicRst_o = 1; Busy_o = 1.
- CfgAck_o = 0; CfgErr_o = 0; DataNd_o = 0; DataValid_o = 0.
- All counters cleared.

Gating (combinational, zero latency):
- DataNd_o = DataNd_i & (state != FLUSH).
- DataValid_o = CicDataValid_i & (state == RUN or state == WAIT_BOUND).

Codes 6 and 7 are reserved. Any CfgWr_i with a reserved code, or while Busy_o = 1, produces CfgErr_o one cycle later. A rejected request changes nothing.

States:
- RUN:
  - CfgWr_i with code equal to DecimFactor_o: CfgAck_o next cycle, stay in RUN.
  - CfgWr_i with any other valid code: latch the code into pending, clear the timeout counter, go to WAIT_BOUND.
- WAIT_BOUND:
  - Samples still flow; the timeout counter increments each cycle.
  - On CicDataValid_i = 1 (that sample is delivered), or when the counter reaches BoundTimeout: go to FLUSH next cycle.
  - If both conditions occur in the same cycle, treat it as the boundary case.
- FLUSH:
  - On entry: DecimFactor_o <= pending; CicRst_o = 1 for exactly FlushCycles cycles.
  - Then go to SETTLE, clear the settle counter, CicRst_o = 0.
- SETTLE:
  - Count CicDataValid_i pulses, all suppressed.
  - After N*M pulses: go to RUN and assert CfgAck_o for one cycle.
  - The post-reset pass also takes this path (FLUSH, then SETTLE, then RUN) but generates no CfgAck_o.
- Rst_i mid-operation: abort immediately to the reset state. Any pending request is discarded with no ack and no err.

All control outputs except the gating signals are registered. Busy_o = (state != RUN).

Optional Feature:
CIC_RATE_CTRL_STATUS_EN
- Defined:
  - Adds output DropCnt_o [7:0]: counts CicDataValid_i pulses suppressed in FLUSH/SETTLE, saturating at 255.
  - Cleared by Rst_i and on each CfgAck_o.
  - Adds output TimeoutFlag_o: sticky, set when WAIT_BOUND exits on timeout, cleared by Rst_i.
- Not defined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset release with DataNd_i toggling every cycle, N=2, M=1 → CicRst_o high 4 cycles, first 2 CicDataValid_i pulses suppressed, then Busy_o=0; no CfgAck_o.
- In RUN, CfgWr_i with CfgDecim_i=3 (current 0) → WAIT_BOUND; next CicDataValid_i passes to DataValid_o; DecimFactor_o=3 at FLUSH entry; 4 flush cycles; 2 outputs dropped; CfgAck_o one pulse; Busy_o=0.
- CfgWr_i with code 7 in RUN, and with code 2 while Busy_o=1 → CfgErr_o one pulse each; DecimFactor_o and state unchanged.
- CfgWr_i with code equal to current → CfgAck_o on the next cycle; CicRst_o never asserted.
- DataNd_i held low after a request → FLUSH entered after 255 cycles; with STATUS_EN, TimeoutFlag_o=1 and DropCnt_o=2 read before the ack clears it.
- Rst_i pulsed during SETTLE → return to FLUSH with DecimFactor_o=DefaultDecim; no CfgAck_o from the aborted request.

Source files
------------

// File: rtl/cic_rate_ctrl.sv
// Run-time decimation-rate controller for a CIC filter: flushes, reprograms and settles the filter.
// Optional status outputs (DropCnt_o, TimeoutFlag_o) are enabled with `define CIC_RATE_CTRL_STATUS_EN.
module cic_rate_ctrl #(
    parameter int         N            = 2,
    parameter int         M            = 1,
    parameter int         OutDataWidth = 28,
    parameter logic [2:0] DefaultDecim = 3'd0,
    parameter int         FlushCycles  = 4,
    parameter int         BoundTimeout = 255
) (
    input  logic                    Clk_i,
    input  logic                    Rst_i,
    input  logic [2:0]              CfgDecim_i,
    input  logic                    CfgWr_i,
    output logic                    CfgAck_o,
    output logic                    CfgErr_o,
    output logic                    Busy_o,
    input  logic                    DataNd_i,
    output logic                    DataNd_o,
    output logic [2:0]              DecimFactor_o,
    output logic                    CicRst_o,
    input  logic [OutDataWidth-1:0] CicData_i,
    input  logic                    CicDataValid_i,
    output logic [OutDataWidth-1:0] Data_o,
    output logic                    DataValid_o
`ifdef CIC_RATE_CTRL_STATUS_EN
   ,output logic [7:0]              DropCnt_o,
    output logic                    TimeoutFlag_o
`endif
);

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_WAIT_BOUND = 2'd1;
    localparam logic [1:0] ST_FLUSH      = 2'd2;
    localparam logic [1:0] ST_SETTLE     = 2'd3;

    localparam int SettlePulses = N * M;

    logic [1:0] state;
    logic [2:0] pending;
    logic [2:0] decim;
    logic       cic_rst;
    logic       ack;
    logic       err;
    logic       ack_en;
    logic [3:0] flush_cnt;
    logic [7:0] bound_cnt;
    logic [7:0] settle_cnt;

    logic       busy;
    logic       code_reserved;
    logic       bound_timeout;

    assign busy          = (state != ST_RUN);
    assign code_reserved = CfgDecim_i[2] & CfgDecim_i[1];
    // A real boundary sample takes precedence over a coincident timeout.
    assign bound_timeout = (state == ST_WAIT_BOUND) && !CicDataValid_i &&
                           (bound_cnt == 8'(BoundTimeout - 1));

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state      <= ST_FLUSH;
            pending    <= DefaultDecim;
            decim      <= DefaultDecim;
            cic_rst    <= 1'b1;
            ack        <= 1'b0;
            err        <= 1'b0;
            ack_en     <= 1'b0;
            flush_cnt  <= '0;
            bound_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            ack <= 1'b0;
            err <= CfgWr_i && (busy || code_reserved);

            case (state)
                ST_RUN: begin
                    if (CfgWr_i && !code_reserved) begin
                        if (CfgDecim_i == decim) begin
                            ack <= 1'b1;
                        end else begin
                            pending   <= CfgDecim_i;
                            bound_cnt <= '0;
                            state     <= ST_WAIT_BOUND;
                        end
                    end
                end

                ST_WAIT_BOUND: begin
                    if (CicDataValid_i || bound_timeout) begin
                        state     <= ST_FLUSH;
                        decim     <= pending;
                        cic_rst   <= 1'b1;
                        flush_cnt <= '0;
                        ack_en    <= 1'b1;
                    end else begin
                        bound_cnt <= bound_cnt + 8'd1;
                    end
                end

                ST_FLUSH: begin
                    if (flush_cnt == 4'(FlushCycles - 1)) begin
                        state      <= ST_SETTLE;
                        cic_rst    <= 1'b0;
                        settle_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + 4'd1;
                    end
                end

                default: begin
                    // The post-reset pass leaves ack_en clear, so it settles silently.
                    if (CicDataValid_i) begin
                        if (settle_cnt == 8'(SettlePulses - 1)) begin
                            state  <= ST_RUN;
                            ack    <= ack_en;
                            ack_en <= 1'b0;
                        end else begin
                            settle_cnt <= settle_cnt + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef CIC_RATE_CTRL_STATUS_EN
    logic [7:0] drop_cnt;
    logic       timeout_flag;

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            drop_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (ack) begin
                drop_cnt <= '0;
            end else if (CicDataValid_i && (state == ST_FLUSH || state == ST_SETTLE) &&
                         (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (bound_timeout) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign DropCnt_o     = drop_cnt;
    assign TimeoutFlag_o = timeout_flag;
`else
    // Status counters are not built in this configuration.
`endif

    assign CfgAck_o      = ack;
    assign CfgErr_o      = err;
    assign Busy_o        = busy;
    assign DecimFactor_o = decim;
    assign CicRst_o      = cic_rst | Rst_i;
    assign DataNd_o      = DataNd_i & (state != ST_FLUSH);
    assign DataValid_o   = CicDataValid_i & (state == ST_RUN || state == ST_WAIT_BOUND);
    assign Data_o        = CicData_i;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Testbench for cic_rate_ctrl: directed vector table, corner sequences and a randomized run
// checked against a counter/deadline-based reference model.
module tb_cic_rate_ctrl;

    localparam int         N   = 2;
    localparam int         M   = 1;
    localparam int         W   = 28;
    localparam int         F   = 4;
    localparam int         BT  = 255;
    localparam logic [2:0] DEF = 3'd0;

    logic         Clk_i = 1'b0;
    logic         Rst_i;
    logic [2:0]   CfgDecim_i;
    logic         CfgWr_i;
    logic         CfgAck_o;
    logic         CfgErr_o;
    logic         Busy_o;
    logic         DataNd_i;
    logic         DataNd_o;
    logic [2:0]   DecimFactor_o;
    logic         CicRst_o;
    logic [W-1:0] CicData_i;
    logic         CicDataValid_i;
    logic [W-1:0] Data_o;
    logic         DataValid_o;
`ifdef CIC_RATE_CTRL_STATUS_EN
    logic [7:0]   DropCnt_o;
    logic         TimeoutFlag_o;
`endif

    always #5 Clk_i = ~Clk_i;

    cic_rate_ctrl #(
        .N(N), .M(M), .OutDataWidth(W), .DefaultDecim(DEF),
        .FlushCycles(F), .BoundTimeout(BT)
    ) dut (
        .Clk_i(Clk_i), .Rst_i(Rst_i),
        .CfgDecim_i(CfgDecim_i), .CfgWr_i(CfgWr_i),
        .CfgAck_o(CfgAck_o), .CfgErr_o(CfgErr_o), .Busy_o(Busy_o),
        .DataNd_i(DataNd_i), .DataNd_o(DataNd_o),
        .DecimFactor_o(DecimFactor_o), .CicRst_o(CicRst_o),
        .CicData_i(CicData_i), .CicDataValid_i(CicDataValid_i),
        .Data_o(Data_o), .DataValid_o(DataValid_o)
`ifdef CIC_RATE_CTRL_STATUS_EN
       ,.DropCnt_o(DropCnt_o), .TimeoutFlag_o(TimeoutFlag_o)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: phases expressed as remaining work / absolute deadlines.
    bit         m_wait;
    int         m_deadline;
    int         m_flush_left;
    int         m_settle_left;
    logic [2:0] m_decim;
    logic [2:0] m_pending;
    bit         m_ack;
    bit         m_err;
    bit         m_armed;
    int         m_drop;
    bit         m_tflag;

    typedef struct {
        bit         rst;
        bit         wr;
        logic [2:0] code;
        bit         nd;
        bit         vld;
        bit         busy;
        bit         crst;
        logic [2:0] decim;
        bit         ack;
        bit         err;
        bit         ndo;
        bit         dvo;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(bit rst, bit wr, logic [2:0] code, bit nd, bit vld,
                                bit busy, bit crst, logic [2:0] decim,
                                bit ack, bit err, bit ndo, bit dvo);
        vec_t v;
        v.rst = rst; v.wr = wr; v.code = code; v.nd = nd; v.vld = vld;
        v.busy = busy; v.crst = crst; v.decim = decim;
        v.ack = ack; v.err = err; v.ndo = ndo; v.dvo = dvo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_run();
        return !m_wait && (m_flush_left == 0) && (m_settle_left == 0);
    endfunction

    task automatic check_model();
        chk("busy",   32'(Busy_o),        32'(!m_run()));
        chk("cicrst", 32'(CicRst_o),      32'(Rst_i || (m_flush_left > 0)));
        chk("decim",  32'(DecimFactor_o), 32'(m_decim));
        chk("ack",    32'(CfgAck_o),      32'(m_ack));
        chk("err",    32'(CfgErr_o),      32'(m_err));
        chk("nd_o",   32'(DataNd_o),      32'(DataNd_i && (m_flush_left == 0)));
        chk("valid_o", 32'(DataValid_o),
            32'(CicDataValid_i && (m_flush_left == 0) && (m_settle_left == 0)));
        chk("data_o", 32'(Data_o),        32'(CicData_i));
`ifdef CIC_RATE_CTRL_STATUS_EN
        chk("dropcnt", 32'(DropCnt_o),    32'(m_drop));
        chk("tflag",   32'(TimeoutFlag_o), 32'(m_tflag));
`endif
    endtask

    task automatic model_edge();
        bit was_run;
        bit new_ack;
        was_run = m_run();
        if (Rst_i) begin
            m_wait = 0; m_flush_left = F; m_settle_left = 0;
            m_decim = DEF; m_pending = DEF;
            m_ack = 0; m_err = 0; m_armed = 0; m_drop = 0; m_tflag = 0;
        end else begin
            new_ack = 0;
            if (m_ack) m_drop = 0;
            else if (CicDataValid_i && (m_flush_left > 0 || m_settle_left > 0) && m_drop < 255)
                m_drop++;
            m_err = CfgWr_i && (!was_run || CfgDecim_i >= 3'd6);
            if (was_run) begin
                if (CfgWr_i && CfgDecim_i < 3'd6) begin
                    if (CfgDecim_i == m_decim) new_ack = 1;
                    else begin
                        m_pending  = CfgDecim_i;
                        m_wait     = 1;
                        m_deadline = cyc + BT;
                    end
                end
            end else if (m_wait) begin
                if (CicDataValid_i || cyc == m_deadline) begin
                    if (!CicDataValid_i) m_tflag = 1;
                    m_wait = 0;
                    m_flush_left = F;
                    m_decim = m_pending;
                    m_armed = 1;
                end
            end else if (m_flush_left > 0) begin
                m_flush_left--;
                if (m_flush_left == 0) m_settle_left = N * M;
            end else if (CicDataValid_i) begin
                m_settle_left--;
                if (m_settle_left == 0) begin
                    new_ack = m_armed;
                    m_armed = 0;
                end
            end
            m_ack = new_ack;
        end
    endtask

    task automatic drive(input bit rst, input bit wr, input logic [2:0] code,
                         input bit nd, input bit vld);
        Rst_i = rst; CfgWr_i = wr; CfgDecim_i = code;
        DataNd_i = nd; CicDataValid_i = vld;
        CicData_i = W'($urandom);
    endtask

    task automatic advance();
        @(posedge Clk_i);
        model_edge();
        cyc++;
        @(negedge Clk_i);
    endtask

    task automatic step(input bit rst, input bit wr, input logic [2:0] code,
                        input bit nd, input bit vld);
        drive(rst, wr, code, nd, vld);
        #1;
        check_model();
        advance();
    endtask

    int wc;
    int acks;

    initial begin
        tbl[0]  = mk(1,0,3'd0,1,0, 1,1,3'd0,0,0,0,0);
        tbl[1]  = mk(0,0,3'd0,0,1, 1,1,3'd0,0,0,0,0);
        tbl[2]  = mk(0,0,3'd0,1,0, 1,1,3'd0,0,0,0,0);
        tbl[3]  = mk(0,0,3'd0,0,0, 1,1,3'd0,0,0,0,0);
        tbl[4]  = mk(0,0,3'd0,1,1, 1,1,3'd0,0,0,0,0);
        tbl[5]  = mk(0,0,3'd0,0,1, 1,0,3'd0,0,0,0,0);
        tbl[6]  = mk(0,0,3'd0,1,0, 1,0,3'd0,0,0,1,0);
        tbl[7]  = mk(0,0,3'd0,0,1, 1,0,3'd0,0,0,0,0);
        tbl[8]  = mk(0,1,3'd0,1,1, 0,0,3'd0,0,0,1,1);
        tbl[9]  = mk(0,1,3'd7,0,0, 0,0,3'd0,1,0,0,0);
        tbl[10] = mk(0,0,3'd0,0,0, 0,0,3'd0,0,1,0,0);
        tbl[11] = mk(0,1,3'd2,0,0, 0,0,3'd0,0,0,0,0);
        tbl[12] = mk(0,1,3'd2,1,0, 1,0,3'd0,0,0,1,0);
        tbl[13] = mk(0,0,3'd0,1,1, 1,0,3'd0,0,1,1,1);
        tbl[14] = mk(0,0,3'd0,1,1, 1,1,3'd2,0,0,0,0);

        // Unchecked first reset edge: outputs are undefined before it.
        drive(1, 0, 3'd0, 0, 0);
        @(posedge Clk_i);
        model_edge();
        cyc++;
        @(negedge Clk_i);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rst, tbl[i].wr, tbl[i].code, tbl[i].nd, tbl[i].vld);
            #1;
            chk("tbl_busy",   32'(Busy_o),        32'(tbl[i].busy));
            chk("tbl_cicrst", 32'(CicRst_o),      32'(tbl[i].crst));
            chk("tbl_decim",  32'(DecimFactor_o), 32'(tbl[i].decim));
            chk("tbl_ack",    32'(CfgAck_o),      32'(tbl[i].ack));
            chk("tbl_err",    32'(CfgErr_o),      32'(tbl[i].err));
            chk("tbl_nd_o",   32'(DataNd_o),      32'(tbl[i].ndo));
            chk("tbl_valid_o", 32'(DataValid_o),  32'(tbl[i].dvo));
            advance();
        end

        // Finish the pending change: remaining flush cycles, then settle pulses.
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            if (CfgAck_o) acks++;
            step(0, 0, 3'd0, 1, (i % 2) == 1);
        end
        chk("change_ack_count", 32'(acks), 32'd1);
        chk("change_decim", 32'(DecimFactor_o), 32'd2);

        // Boundary timeout: no filter output after the request.
        step(0, 1, 3'd3, 0, 0);
        wc = 0;
        while (!CicRst_o && wc < 400) begin
            step(0, 0, 3'd0, 0, 0);
            wc++;
        end
        chk("timeout_wait_cycles", 32'(wc), 32'(BT));
`ifdef CIC_RATE_CTRL_STATUS_EN
        chk("timeout_flag_set", 32'(TimeoutFlag_o), 32'd1);
`endif
        acks = 0;
        for (int i = 0; i < 16; i++) begin
            if (CfgAck_o) acks++;
            step(0, 0, 3'd0, 0, (i >= 4) && (i % 2 == 0));
        end
        chk("timeout_ack_count", 32'(acks), 32'd1);
        chk("timeout_decim", 32'(DecimFactor_o), 32'd3);

        // Reset while settling a new rate: no ack, default rate restored.
        step(0, 1, 3'd5, 0, 0);
        step(0, 0, 3'd0, 0, 1);
        for (int i = 0; i < F; i++) step(0, 0, 3'd0, 0, 0);
        step(0, 0, 3'd0, 0, 1);
        step(1, 0, 3'd0, 0, 0);
        chk("abort_decim", 32'(DecimFactor_o), 32'(DEF));
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            if (CfgAck_o) acks++;
            step(0, 0, 3'd0, 1, (i % 3) == 0);
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        chk("abort_idle", 32'(Busy_o), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 15) == 0,
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
